cpu_run_checker: RTL and testbench

Self-checking run controller that replaces fixed-delay, print-only result checking around risc_v_cpu.
- Sequences the CPU reset and counts execution cycles and data-memory writes.
- Detects program halt when the PC stays stable, or stops on a cycle budget (timeout).
- After halt, scans a parametrised array region through a read port and checks ordering, then reports pass/fail with the first offending index.
- Sits beside the CPU and data memory in the test harness. Synthesizable so it can also run on an FPGA bring-up board.

---
 rtl/cpu_run_checker.sv | 205 ++++++++++++++++++++
 tb/tb_cpu_run_checker.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_checker.sv
// cpu_run_checker: sequences CPU reset, counts run cycles and data-memory
// writes, detects halt (stable PC) or timeout, then scans an array region
// and reports whether it is ordered, with the first offending index.
// Optional build macro RUN_CHECKER_SUM_EN adds an element-sum check (sum_ok).
module cpu_run_checker #(
    parameter logic [31:0] BASE_ADDR    = 32'h100,
    parameter int unsigned ARRAY_LEN    = 5,
    parameter bit          CHECK_SIGNED = 1'b0,
    parameter bit          DESCENDING   = 1'b0,
    parameter int unsigned RST_CYCLES   = 2,
    parameter int unsigned HALT_STABLE  = 8,
    parameter int unsigned MAX_CYCLES   = 1000,
    parameter int unsigned CNT_W        = 32
`ifdef RUN_CHECKER_SUM_EN
    ,
    parameter logic [31:0] EXPECTED_SUM = 32'd15
`endif
) (
    input  logic             clk,
    input  logic             rst,
    output logic             cpu_rst,
    input  logic [31:0]      debug_pc,
    input  logic             dmem_we,
    output logic [31:0]      chk_addr,
    input  logic [31:0]      chk_rdata,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
`ifdef RUN_CHECKER_SUM_EN
    output logic             sum_ok,
`endif
    output logic [15:0]      fail_index,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] write_count
);

    localparam int unsigned RC_W  = $clog2(RST_CYCLES + 1);
    localparam int unsigned STB_W = $clog2(HALT_STABLE + 1);
    localparam int unsigned IDX_W = (ARRAY_LEN > 1) ? $clog2(ARRAY_LEN) : 1;

    typedef enum logic [1:0] {S_RESET, S_RUN, S_SCAN, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [RC_W-1:0]    rst_cnt_q, rst_cnt_d;
    logic [STB_W-1:0]   stable_q, stable_d;
    logic [31:0]        last_pc_q, last_pc_d;
    logic               pc_seen_q, pc_seen_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [31:0]        prev_q, prev_d;
    logic               bad_q, bad_d;
    logic               violation;
    logic               cpu_rst_d, busy_d, done_d, pass_d, timeout_d;
    logic [31:0]        chk_addr_d;
    logic [15:0]        fail_index_d;
    logic [CNT_W-1:0]   cycle_d, write_d;
`ifdef RUN_CHECKER_SUM_EN
    logic [31:0]        sum_q, sum_d;
    logic               sum_ok_d;
`endif

    // State and datapath registers; rst returns everything to reset values
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_RESET;
            rst_cnt_q   <= '0;
            stable_q    <= '0;
            last_pc_q   <= '0;
            pc_seen_q   <= 1'b0;
            idx_q       <= '0;
            prev_q      <= '0;
            bad_q       <= 1'b0;
            cpu_rst     <= 1'b1;
            busy        <= 1'b1;
            done        <= 1'b0;
            pass        <= 1'b0;
            timeout     <= 1'b0;
            chk_addr    <= BASE_ADDR;
            fail_index  <= '0;
            cycle_count <= '0;
            write_count <= '0;
`ifdef RUN_CHECKER_SUM_EN
            sum_q       <= '0;
            sum_ok      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rst_cnt_q   <= rst_cnt_d;
            stable_q    <= stable_d;
            last_pc_q   <= last_pc_d;
            pc_seen_q   <= pc_seen_d;
            idx_q       <= idx_d;
            prev_q      <= prev_d;
            bad_q       <= bad_d;
            cpu_rst     <= cpu_rst_d;
            busy        <= busy_d;
            done        <= done_d;
            pass        <= pass_d;
            timeout     <= timeout_d;
            chk_addr    <= chk_addr_d;
            fail_index  <= fail_index_d;
            cycle_count <= cycle_d;
            write_count <= write_d;
`ifdef RUN_CHECKER_SUM_EN
            sum_q       <= sum_d;
            sum_ok      <= sum_ok_d;
`endif
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d      = state_q;
        rst_cnt_d    = rst_cnt_q;
        stable_d     = stable_q;
        last_pc_d    = last_pc_q;
        pc_seen_d    = pc_seen_q;
        idx_d        = idx_q;
        prev_d       = prev_q;
        bad_d        = bad_q;
        violation    = 1'b0;
        cpu_rst_d    = cpu_rst;
        busy_d       = busy;
        done_d       = done;
        pass_d       = pass;
        timeout_d    = timeout;
        chk_addr_d   = chk_addr;
        fail_index_d = fail_index;
        cycle_d      = cycle_count;
        write_d      = write_count;
`ifdef RUN_CHECKER_SUM_EN
        sum_d        = sum_q;
        sum_ok_d     = sum_ok;
`endif

        unique case (state_q)
            S_RESET: begin
                if (rst_cnt_q == RC_W'(RST_CYCLES - 1)) begin
                    state_d   = S_RUN;
                    cpu_rst_d = 1'b0;
                end else begin
                    rst_cnt_d = rst_cnt_q + RC_W'(1);
                end
            end

            S_RUN: begin
                if (cycle_count != '1) cycle_d = cycle_count + CNT_W'(1);
                if (dmem_we && (write_count != '1)) write_d = write_count + CNT_W'(1);
                // The first run cycle has no previous PC, so it counts as a change
                pc_seen_d = 1'b1;
                last_pc_d = debug_pc;
                if (pc_seen_q && (debug_pc == last_pc_q)) stable_d = stable_q + STB_W'(1);
                else                                      stable_d = '0;
                // Halt takes priority over the cycle budget
                if (stable_d == STB_W'(HALT_STABLE)) begin
                    state_d = S_SCAN;
                end else if (cycle_count == CNT_W'(MAX_CYCLES - 1)) begin
                    state_d   = S_DONE;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    pass_d    = 1'b0;
                    timeout_d = 1'b1;
                end
            end

            S_SCAN: begin
                prev_d = chk_rdata;
                if (idx_q != '0) begin
                    if (DESCENDING) violation = CHECK_SIGNED ? ($signed(chk_rdata) > $signed(prev_q))
                                                             : (chk_rdata > prev_q);
                    else            violation = CHECK_SIGNED ? ($signed(chk_rdata) < $signed(prev_q))
                                                             : (chk_rdata < prev_q);
                    if (violation && !bad_q) begin
                        bad_d        = 1'b1;
                        fail_index_d = 16'(idx_q);
                    end
                end
`ifdef RUN_CHECKER_SUM_EN
                sum_d = sum_q + chk_rdata;
`endif
                if (idx_q == IDX_W'(ARRAY_LEN - 1)) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
`ifdef RUN_CHECKER_SUM_EN
                    sum_ok_d = (sum_d == EXPECTED_SUM);
                    pass_d   = !bad_d && (sum_d == EXPECTED_SUM);
`else
                    pass_d   = !bad_d;
`endif
                end else begin
                    idx_d      = idx_q + IDX_W'(1);
                    chk_addr_d = chk_addr + 32'd4;
                end
            end

            S_DONE: begin
                state_d = S_DONE;
            end

            default: state_d = S_RESET;
        endcase
    end

endmodule

// File: tb/tb_cpu_run_checker.sv
// Randomized self-checking bench for cpu_run_checker: five instances with
// different ordering/budget parameters, checked against a behavioural model.
module tb_cpu_run_checker;

    localparam int NI   = 5;
    localparam int HALT = 8;
    localparam int RSTC = 2;
    localparam int LEN  [NI] = '{5, 5, 3, 3, 5};
    localparam int SGN  [NI] = '{0, 0, 1, 0, 0};
    localparam int DSC  [NI] = '{0, 0, 0, 0, 1};
    localparam int MAXC [NI] = '{1000, 50, 1000, 1000, 1000};

    logic        clk = 1'b0;
    logic        rst_v     [NI];
    logic        cpu_rst_v [NI];
    logic [31:0] pc_v      [NI];
    logic        we_v      [NI];
    logic [31:0] addr_v    [NI];
    logic [31:0] rdata_v   [NI];
    logic        busy_v    [NI];
    logic        done_v    [NI];
    logic        pass_v    [NI];
    logic        to_v      [NI];
    logic [15:0] fidx_v    [NI];
    logic [31:0] cyc_v     [NI];
    logic [31:0] wr_v      [NI];
`ifdef RUN_CHECKER_SUM_EN
    logic        sum_ok_v  [NI];
`endif
    logic [31:0] mem [NI][8];
    logic [31:0] pc_seq [$];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Combinational data memory for each instance
    for (genvar g = 0; g < NI; g++) begin : g_mem
        logic [31:0] off;
        assign off = addr_v[g] - 32'h100;
        assign rdata_v[g] = (off[31:5] == 27'd0 && off[1:0] == 2'b00) ? mem[g][off[4:2]] : 32'hDEAD_BEEF;
    end

    cpu_run_checker u_c0 (
        .clk(clk), .rst(rst_v[0]), .cpu_rst(cpu_rst_v[0]), .debug_pc(pc_v[0]), .dmem_we(we_v[0]),
        .chk_addr(addr_v[0]), .chk_rdata(rdata_v[0]), .busy(busy_v[0]), .done(done_v[0]),
        .pass(pass_v[0]), .timeout(to_v[0]),
`ifdef RUN_CHECKER_SUM_EN
        .sum_ok(sum_ok_v[0]),
`endif
        .fail_index(fidx_v[0]), .cycle_count(cyc_v[0]), .write_count(wr_v[0]));

    cpu_run_checker #(.MAX_CYCLES(50)) u_c1 (
        .clk(clk), .rst(rst_v[1]), .cpu_rst(cpu_rst_v[1]), .debug_pc(pc_v[1]), .dmem_we(we_v[1]),
        .chk_addr(addr_v[1]), .chk_rdata(rdata_v[1]), .busy(busy_v[1]), .done(done_v[1]),
        .pass(pass_v[1]), .timeout(to_v[1]),
`ifdef RUN_CHECKER_SUM_EN
        .sum_ok(sum_ok_v[1]),
`endif
        .fail_index(fidx_v[1]), .cycle_count(cyc_v[1]), .write_count(wr_v[1]));

    cpu_run_checker #(.ARRAY_LEN(3), .CHECK_SIGNED(1'b1)) u_c2 (
        .clk(clk), .rst(rst_v[2]), .cpu_rst(cpu_rst_v[2]), .debug_pc(pc_v[2]), .dmem_we(we_v[2]),
        .chk_addr(addr_v[2]), .chk_rdata(rdata_v[2]), .busy(busy_v[2]), .done(done_v[2]),
        .pass(pass_v[2]), .timeout(to_v[2]),
`ifdef RUN_CHECKER_SUM_EN
        .sum_ok(sum_ok_v[2]),
`endif
        .fail_index(fidx_v[2]), .cycle_count(cyc_v[2]), .write_count(wr_v[2]));

    cpu_run_checker #(.ARRAY_LEN(3)) u_c3 (
        .clk(clk), .rst(rst_v[3]), .cpu_rst(cpu_rst_v[3]), .debug_pc(pc_v[3]), .dmem_we(we_v[3]),
        .chk_addr(addr_v[3]), .chk_rdata(rdata_v[3]), .busy(busy_v[3]), .done(done_v[3]),
        .pass(pass_v[3]), .timeout(to_v[3]),
`ifdef RUN_CHECKER_SUM_EN
        .sum_ok(sum_ok_v[3]),
`endif
        .fail_index(fidx_v[3]), .cycle_count(cyc_v[3]), .write_count(wr_v[3]));

    cpu_run_checker #(.DESCENDING(1'b1)) u_c4 (
        .clk(clk), .rst(rst_v[4]), .cpu_rst(cpu_rst_v[4]), .debug_pc(pc_v[4]), .dmem_we(we_v[4]),
        .chk_addr(addr_v[4]), .chk_rdata(rdata_v[4]), .busy(busy_v[4]), .done(done_v[4]),
        .pass(pass_v[4]), .timeout(to_v[4]),
`ifdef RUN_CHECKER_SUM_EN
        .sum_ok(sum_ok_v[4]),
`endif
        .fail_index(fidx_v[4]), .cycle_count(cyc_v[4]), .write_count(wr_v[4]));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] seq_at(input int k);
        if (k < pc_seq.size()) return pc_seq[k];
        return pc_seq[pc_seq.size() - 1];
    endfunction

    // Run cycle at which the run ends: halt when the last HALT+1 PCs are equal
    function automatic int model_stop(input int id, output bit halted);
        halted = 1'b0;
        for (int i = 1; i <= MAXC[id]; i++) begin
            if (i >= HALT + 1) begin
                bit same = 1'b1;
                for (int k = i - HALT - 1; k < i; k++)
                    if (seq_at(k) != seq_at(i - 1)) same = 1'b0;
                if (same) begin
                    halted = 1'b1;
                    return i;
                end
            end
            if (i == MAXC[id]) return i;
        end
        return 0;
    endfunction

    function automatic void model_order(input int id, output bit ordered, output int fidx,
                                        output logic [31:0] sum);
        ordered = 1'b1;
        fidx    = 0;
        sum     = 32'd0;
        for (int k = 0; k < LEN[id]; k++) begin
            bit bad;
            sum = sum + mem[id][k];
            if (k == 0) continue;
            if (SGN[id] != 0)
                bad = (DSC[id] != 0) ? ($signed(mem[id][k]) > $signed(mem[id][k-1]))
                                     : ($signed(mem[id][k]) < $signed(mem[id][k-1]));
            else
                bad = (DSC[id] != 0) ? (mem[id][k] > mem[id][k-1]) : (mem[id][k] < mem[id][k-1]);
            if (bad && ordered) begin
                ordered = 1'b0;
                fidx    = k;
            end
        end
    endfunction

    task automatic set_mem(input int id, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] c, input logic [31:0] d, input logic [31:0] e);
        mem[id][0] = a; mem[id][1] = b; mem[id][2] = c; mem[id][3] = d; mem[id][4] = e;
        for (int k = 5; k < 8; k++) mem[id][k] = 32'h0;
    endtask

    task automatic seq_halt(input int n_adv, input int n_hold, input bit rnd);
        logic [31:0] v = 32'h1000;
        pc_seq.delete();
        for (int k = 0; k < n_adv; k++) begin
            if (!rnd || k == 0 || $urandom_range(0, 3) != 0) v = v + 32'd4;
            pc_seq.push_back(v);
        end
        for (int k = 0; k < n_hold; k++) pc_seq.push_back(v);
    endtask

    task automatic seq_toggle(input int n, input bit rnd);
        logic [31:0] v = 32'h2000;
        pc_seq.delete();
        for (int k = 0; k < n; k++) begin
            if (!rnd || $urandom_range(0, 2) != 0) v = v ^ 32'h4;
            pc_seq.push_back(v);
        end
    endtask

    task automatic check_reset(input int id);
        check("rst_cpu_rst", cpu_rst_v[id], 1);
        check("rst_busy", busy_v[id], 1);
        check("rst_done", done_v[id], 0);
        check("rst_pass", pass_v[id], 0);
        check("rst_timeout", to_v[id], 0);
        check("rst_fail_index", fidx_v[id], 0);
        check("rst_cycle_count", cyc_v[id], 0);
        check("rst_write_count", wr_v[id], 0);
        check("rst_chk_addr", addr_v[id], 32'h100);
`ifdef RUN_CHECKER_SUM_EN
        check("rst_sum_ok", sum_ok_v[id], 0);
`endif
    endtask

    // One full run on instance id; abort_at>0 asserts rst after that many run-phase clocks
    task automatic run_case(input int id, input int abort_at);
        int e, fidx, wc, p, q;
        bit halted, ordered, moved, seen, exp_pass, exp_sum_ok;
        logic [31:0] sum;
        rst_v[id] = 1'b1; pc_v[id] = 32'h0; we_v[id] = 1'b0;
        @(negedge clk);
        check_reset(id);
        rst_v[id] = 1'b0;
        q = 0;
        while (q < 20) begin
            @(posedge clk); q++;
            @(negedge clk);
            if (!cpu_rst_v[id]) break;
        end
        check("cpu_rst_len", q, RSTC);
        e = model_stop(id, halted);
        model_order(id, ordered, fidx, sum);
        exp_sum_ok = halted && (sum == 32'd15);
`ifdef RUN_CHECKER_SUM_EN
        exp_pass = halted && ordered && exp_sum_ok;
`else
        exp_pass = halted && ordered;
`endif
        wc = 0; p = 0; moved = 1'b0; seen = 1'b0;
        while (p < MAXC[id] + LEN[id] + 10) begin
            pc_v[id] = seq_at(p);
            we_v[id] = 1'($urandom_range(0, 1));
            @(posedge clk); p++;
            if (we_v[id] && p <= e) wc++;
            @(negedge clk);
            if (addr_v[id] != 32'h100) moved = 1'b1;
            if (abort_at > 0 && p == abort_at) begin
                rst_v[id] = 1'b1;
                #1;
                check_reset(id);
                return;
            end
            if (done_v[id]) begin
                seen = 1'b1;
                break;
            end
        end
        check("done_seen", seen, 1);
        check("done_latency", p, halted ? e + LEN[id] : e);
        check("pass", pass_v[id], exp_pass);
        check("timeout", to_v[id], !halted);
        check("fail_index", fidx_v[id], halted ? fidx : 0);
        check("cycle_count", cyc_v[id], e);
        check("write_count", wr_v[id], wc);
        check("busy_done", busy_v[id], 0);
        check("cpu_rst_run", cpu_rst_v[id], 0);
        if (!halted) check("addr_stays_base", moved, 0);
`ifdef RUN_CHECKER_SUM_EN
        check("sum_ok", sum_ok_v[id], exp_sum_ok);
`endif
        // Outputs and counters freeze in DONE even with writes and PC motion
        we_v[id] = 1'b1;
        repeat (3) begin
            pc_v[id] = $urandom;
            @(negedge clk);
        end
        we_v[id] = 1'b0;
        check("freeze_cycle", cyc_v[id], e);
        check("freeze_write", wr_v[id], wc);
        check("freeze_done", done_v[id], 1);
        check("freeze_pass", pass_v[id], exp_pass);
    endtask

    initial begin
        for (int i = 0; i < NI; i++) begin
            rst_v[i] = 1'b1; pc_v[i] = 32'h0; we_v[i] = 1'b0;
            set_mem(i, 0, 0, 0, 0, 0);
        end
        repeat (2) @(negedge clk);

        // Sorted array, 20 advancing PCs then 8 holds
        set_mem(0, 1, 2, 3, 4, 5);
        seq_halt(20, 8, 1'b0);
        run_case(0, 0);
        // Out-of-order array, same run shape
        set_mem(0, 1, 3, 2, 4, 2);
        run_case(0, 0);
        // Reset mid-scan at idx 2, then rerun
        run_case(0, 30);
        run_case(0, 0);
        // Toggling PC hits the 50-cycle budget
        seq_toggle(60, 1'b0);
        run_case(1, 0);
        // Signed versus unsigned ordering of the same data
        seq_halt(5, 9, 1'b0);
        set_mem(2, 32'hFFFF_FFFD, 0, 2, 0, 0);
        set_mem(3, 32'hFFFF_FFFD, 0, 2, 0, 0);
        run_case(2, 0);
        run_case(3, 0);
        // Descending with equal neighbours, then sum-only differences
        set_mem(4, 5, 5, 3, 2, 1);
        run_case(4, 0);
        set_mem(4, 5, 4, 3, 2, 1);
        run_case(4, 0);
        set_mem(4, 5, 4, 3, 3, 1);
        run_case(4, 0);

        // Randomized runs
        for (int r = 0; r < 16; r++) begin
            int id;
            int pick = $urandom_range(0, 4);
            id = pick;
            if (id == 1) seq_toggle($urandom_range(40, 70), 1'b1);
            else         seq_halt($urandom_range(1, 30), $urandom_range(8, 12), 1'b1);
            if ($urandom_range(0, 1) == 1) begin
                logic [31:0] v = $urandom;
                for (int k = 0; k < 8; k++) begin
                    mem[id][k] = v;
                    v = (DSC[id] != 0) ? v - 32'($urandom_range(0, 3)) : v + 32'($urandom_range(0, 3));
                end
            end else begin
                for (int k = 0; k < 8; k++) mem[id][k] = (k % 2 == 0) ? $urandom : 32'($urandom_range(0, 7));
            end
            run_case(id, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
